// File: rtl/dmem_arb_pkg.sv
// Shared widths, port ids and state encoding for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 3'd0;
    localparam arb_state_t ST_ISSUE = 3'd1;
    localparam arb_state_t ST_CHECK = 3'd2;
    localparam arb_state_t ST_WAIT  = 3'd3;
    localparam arb_state_t ST_RESP  = 3'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic [MASK_W-1:0] sign_mask;
    } req_fields_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way request picker: round-robin on ties when FAIR is nonzero, else port 0 wins.
module dmem_rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int FAIR = 1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = PORT_CPU;
        if (req == 2'b11) begin
            grant_id = (FAIR != 0) ? ~last_grant : PORT_CPU;
        end else if (req[1]) begin
            grant_id = PORT_DMA;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the cached data memory's single load/store port between the CPU (port 0)
// and a DMA/debug master (port 1), re-issuing accesses after miss refills.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int FAIR      = 1,
    parameter int MAX_RETRY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_we,
    input  logic [MASK_W-1:0] p0_sign_mask,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_we,
    input  logic [MASK_W-1:0] p1_sign_mask,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [MASK_W-1:0] mem_sign_mask,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_stall,
    output logic              busy,
    output logic [2:0]        fsm_state
);

    localparam int CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    arb_state_t        state;
    logic              we_q;
    logic              port_q;
    logic              last_grant;
    logic [CNT_W-1:0]  retry_cnt;

    logic              grant_valid;
    logic              grant_id;
    req_fields_t       win;
    logic              hit;
    logic              give_up;
    logic              finish;
    logic [DATA_W-1:0] resp_rdata;

    dmem_rr_pick #(.FAIR(FAIR)) u_pick (
        .req         ({p1_req, p0_req}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        if (grant_id == PORT_DMA) begin
            win.addr      = p1_addr;
            win.wdata     = p1_wdata;
            win.we        = p1_we;
            win.sign_mask = p1_sign_mask;
        end else begin
            win.addr      = p0_addr;
            win.wdata     = p0_wdata;
            win.we        = p0_we;
            win.sign_mask = p0_sign_mask;
        end
    end

    // An access finishes in CHECK either as a hit or when the retry budget is spent.
    always_comb begin
        hit        = !mem_stall;
        give_up    = mem_stall && (retry_cnt == CNT_W'(MAX_RETRY));
        finish     = (state == ST_CHECK) && (hit || give_up);
        resp_rdata = (hit && !we_q) ? mem_read_data : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            we_q           <= 1'b0;
            port_q         <= PORT_CPU;
            last_grant     <= PORT_DMA;
            retry_cnt      <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            p0_ack         <= 1'b0;
            p0_rdata       <= '0;
            p0_err         <= 1'b0;
            p1_ack         <= 1'b0;
            p1_rdata       <= '0;
            p1_err         <= 1'b0;
        end else begin
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            p0_ack       <= 1'b0;
            p0_rdata     <= '0;
            p0_err       <= 1'b0;
            p1_ack       <= 1'b0;
            p1_rdata     <= '0;
            p1_err       <= 1'b0;

            if (finish) begin
                if (port_q == PORT_DMA) begin
                    p1_ack   <= 1'b1;
                    p1_rdata <= resp_rdata;
                    p1_err   <= !hit;
                end else begin
                    p0_ack   <= 1'b1;
                    p0_rdata <= resp_rdata;
                    p0_err   <= !hit;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        mem_addr       <= win.addr;
                        mem_write_data <= win.wdata;
                        mem_sign_mask  <= win.sign_mask;
                        we_q           <= win.we;
                        port_q         <= grant_id;
                        retry_cnt      <= '0;
                        mem_memread    <= !win.we;
                        mem_memwrite   <= win.we;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_CHECK;
                ST_CHECK: begin
                    if (finish) begin
                        state <= ST_RESP;
                    end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!mem_stall) begin
                        mem_memread  <= !we_q;
                        mem_memwrite <= we_q;
                        state        <= ST_ISSUE;
                    end
                end
                ST_RESP: begin
                    last_grant <= port_q;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: hits, misses, retry exhaustion, arbitration and reset.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic        fx_p0_req = 1'b0, fx_p1_req = 1'b0;
    logic [13:0] p0_addr = '0, p1_addr = '0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_we = 1'b0, p1_we = 1'b0;
    logic [3:0]  p0_sign_mask = '0, p1_sign_mask = '0;
    logic [31:0] mem_read_data = '0;
    logic        mem_stall;

    logic        p0_ack, p1_ack, p0_err, p1_err, mem_memread, mem_memwrite, busy;
    logic [31:0] p0_rdata, p1_rdata, mem_write_data;
    logic [13:0] mem_addr;
    logic [3:0]  mem_sign_mask;
    logic [2:0]  fsm_state;

    logic        fx_p0_ack, fx_p1_ack, fx_p0_err, fx_p1_err, fx_memread, fx_memwrite, fx_busy;
    logic [31:0] fx_p0_rdata, fx_p1_rdata, fx_write_data;
    logic [13:0] fx_addr;
    logic [3:0]  fx_sign_mask;
    logic [2:0]  fx_state;

    // memory model: stall_cnt counts remaining stall cycles after a missing strobe
    int          stall_cnt = 0, miss_left = 0, stall_cycles = 0;
    assign mem_stall = (stall_cnt != 0);

    // logs filled by the monitor
    int          strobe_cyc_q[$];
    logic [13:0] strobe_addr_q[$];
    int          ack_port_q[$], ack_cyc_q[$], fx_port_q[$];
    logic [31:0] ack_rdata_q[$];
    logic        ack_err_q[$];
    logic [0:0]  exp_q[$];
    int          rd_cnt = 0, wr_cnt = 0, consec = 0;
    logic        prev_strobe = 1'b0;

    dmem_port_arbiter #(.FAIR(1), .MAX_RETRY(4)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
        .p0_sign_mask(p0_sign_mask), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
        .p1_sign_mask(p1_sign_mask), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_read_data(mem_read_data), .mem_stall(mem_stall),
        .busy(busy), .fsm_state(fsm_state)
    );

    dmem_port_arbiter #(.FAIR(0), .MAX_RETRY(4)) dut_fx (
        .clk(clk), .reset(reset),
        .p0_req(fx_p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we),
        .p0_sign_mask(p0_sign_mask), .p0_ack(fx_p0_ack), .p0_rdata(fx_p0_rdata), .p0_err(fx_p0_err),
        .p1_req(fx_p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we),
        .p1_sign_mask(p1_sign_mask), .p1_ack(fx_p1_ack), .p1_rdata(fx_p1_rdata), .p1_err(fx_p1_err),
        .mem_addr(fx_addr), .mem_write_data(fx_write_data), .mem_sign_mask(fx_sign_mask),
        .mem_memread(fx_memread), .mem_memwrite(fx_memwrite),
        .mem_read_data(mem_read_data), .mem_stall(1'b0),
        .busy(fx_busy), .fsm_state(fx_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_memread || mem_memwrite) begin
            if (miss_left > 0) begin
                stall_cnt = stall_cycles + 1;
                miss_left = miss_left - 1;
            end else if (stall_cnt > 0) begin
                stall_cnt = stall_cnt - 1;
            end
        end else if (stall_cnt > 0) begin
            stall_cnt = stall_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_memread || mem_memwrite) begin
                strobe_cyc_q.push_back(cyc);
                strobe_addr_q.push_back(mem_addr);
                if (mem_memread) rd_cnt++;
                if (mem_memwrite) wr_cnt++;
                if (prev_strobe) consec++;
            end
            prev_strobe = mem_memread || mem_memwrite;
            if (p0_ack) begin
                ack_port_q.push_back(0); ack_cyc_q.push_back(cyc);
                ack_rdata_q.push_back(p0_rdata); ack_err_q.push_back(p0_err);
            end
            if (p1_ack) begin
                ack_port_q.push_back(1); ack_cyc_q.push_back(cyc);
                ack_rdata_q.push_back(p1_rdata); ack_err_q.push_back(p1_err);
            end
            if (fx_p0_ack) fx_port_q.push_back(0);
            if (fx_p1_ack) fx_port_q.push_back(1);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        strobe_cyc_q.delete(); strobe_addr_q.delete();
        ack_port_q.delete(); ack_cyc_q.delete(); fx_port_q.delete();
        ack_rdata_q.delete(); ack_err_q.delete(); exp_q.delete();
        rd_cnt = 0; wr_cnt = 0;
    endtask

    task automatic serve(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
            if (p0_ack) p0_req = 1'b0;
            if (p1_ack) p1_req = 1'b0;
            if (fx_p0_ack) fx_p0_req = 1'b0;
            if (fx_p1_ack) fx_p1_req = 1'b0;
        end while (n < budget && (p0_req || p1_req || fx_p0_req || fx_p1_req || busy || fx_busy));
        chk({tag, "_done"}, 32'(n < budget), 32'd1);
    endtask

    task automatic check_order(input string tag);
        chk({tag, "_n"}, 32'(ack_port_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < ack_port_q.size(); i++)
            chk({tag, "_port"}, 32'(ack_port_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int start;

        // reset state
        step(); step();
        chk("rst_p0_ack", 32'(p0_ack), 32'd0);
        chk("rst_p1_ack", 32'(p1_ack), 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_strobes", 32'({mem_memread, mem_memwrite}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // port-0 load hit
        clear_logs();
        mem_read_data = 32'hDEADBEEF;
        p0_addr = 14'h1004; p0_we = 1'b0; p0_sign_mask = 4'h3; p0_req = 1'b1;
        start = cyc;
        step();
        chk("t1_memread", 32'(mem_memread), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'h1004);
        chk("t1_mask", 32'(mem_sign_mask), 32'h3);
        serve("t1", 20);
        chk("t1_acks", 32'(ack_port_q.size()), 32'd1);
        if (ack_port_q.size() > 0) begin
            chk("t1_port", 32'(ack_port_q[0]), 32'd0);
            chk("t1_lat", 32'(ack_cyc_q[0] - start), 32'd3);
            chk("t1_rdata", ack_rdata_q[0], 32'hDEADBEEF);
            chk("t1_err", 32'(ack_err_q[0]), 32'd0);
        end
        chk("t1_rd_pulses", 32'(rd_cnt), 32'd1);

        // port-1 store with one miss
        clear_logs();
        miss_left = 1; stall_cycles = 2;
        p1_addr = 14'h1010; p1_wdata = 32'h12345678; p1_we = 1'b1; p1_sign_mask = 4'h5; p1_req = 1'b1;
        start = cyc;
        serve("t2", 30);
        chk("t2_wr_pulses", 32'(wr_cnt), 32'd2);
        chk("t2_rd_pulses", 32'(rd_cnt), 32'd0);
        if (strobe_cyc_q.size() == 2) begin
            chk("t2_strobe0", 32'(strobe_cyc_q[0] - start), 32'd1);
            chk("t2_strobe1", 32'(strobe_cyc_q[1] - start), 32'd5);
        end
        chk("t2_wdata", mem_write_data, 32'h12345678);
        chk("t2_mask", 32'(mem_sign_mask), 32'h5);
        chk("t2_acks", 32'(ack_port_q.size()), 32'd1);
        if (ack_port_q.size() > 0) begin
            chk("t2_port", 32'(ack_port_q[0]), 32'd1);
            chk("t2_lat", 32'(ack_cyc_q[0] - start), 32'd7);
            chk("t2_rdata", ack_rdata_q[0], 32'd0);
            chk("t2_err", 32'(ack_err_q[0]), 32'd0);
        end

        // tie after port 1 was served last: port 0 first
        clear_logs();
        mem_read_data = 32'hA5A50001;
        p0_addr = 14'h0100; p0_we = 1'b0; p1_addr = 14'h0200; p1_we = 1'b0;
        p0_req = 1'b1; p1_req = 1'b1; fx_p0_req = 1'b1; fx_p1_req = 1'b1;
        start = cyc;
        serve("t3", 40);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        check_order("t3");
        if (ack_cyc_q.size() == 2) begin
            chk("t3_lat0", 32'(ack_cyc_q[0] - start), 32'd3);
            chk("t3_b2b", 32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'd4);
            chk("t3_rdata1", ack_rdata_q[1], 32'hA5A50001);
        end
        if (strobe_addr_q.size() == 2) begin
            chk("t3_addr0", 32'(strobe_addr_q[0]), 32'h0100);
            chk("t3_addr1", 32'(strobe_addr_q[1]), 32'h0200);
        end
        chk("t3_fx_n", 32'(fx_port_q.size()), 32'd2);
        if (fx_port_q.size() == 2) chk("t3_fx_first", 32'(fx_port_q[0]), 32'd0);

        // lone port-0 access, then tie: port 1 first, fixed-priority copy still port 0
        p0_req = 1'b1;
        serve("t4a", 20);
        clear_logs();
        p0_req = 1'b1; p1_req = 1'b1; fx_p0_req = 1'b1; fx_p1_req = 1'b1;
        serve("t4", 40);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        check_order("t4");
        if (strobe_addr_q.size() == 2) chk("t4_addr0", 32'(strobe_addr_q[0]), 32'h0200);
        chk("t4_fx_n", 32'(fx_port_q.size()), 32'd2);
        if (fx_port_q.size() == 2) chk("t4_fx_first", 32'(fx_port_q[0]), 32'd0);

        // every issue stalls: 5 strobes, then error
        clear_logs();
        miss_left = 5; stall_cycles = 1;
        mem_read_data = 32'hFFFF0000;
        p0_addr = 14'h0444; p0_we = 1'b0; p0_req = 1'b1;
        start = cyc;
        serve("t5", 80);
        chk("t5_strobes", 32'(rd_cnt), 32'd5);
        chk("t5_acks", 32'(ack_port_q.size()), 32'd1);
        if (ack_port_q.size() > 0) begin
            chk("t5_lat", 32'(ack_cyc_q[0] - start), 32'd15);
            chk("t5_err", 32'(ack_err_q[0]), 32'd1);
            chk("t5_rdata", ack_rdata_q[0], 32'd0);
        end

        // reset asserted during WAIT
        clear_logs();
        miss_left = 1; stall_cycles = 3;
        p0_addr = 14'h0888; p0_req = 1'b1;
        step(); step(); step();
        chk("t6_in_wait", 32'(fsm_state), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_addr", 32'(mem_addr), 32'd0);
        chk("t6_strobes", 32'({mem_memread, mem_memwrite}), 32'd0);
        chk("t6_ack", 32'({p0_ack, p1_ack}), 32'd0);
        p0_req = 1'b0;
        step(); step(); step();
        reset = 1'b0;
        step(); step();
        chk("t6_no_ack", 32'(ack_port_q.size()), 32'd0);
        clear_logs();
        mem_read_data = 32'h0BADF00D;
        p0_addr = 14'h0020; p0_req = 1'b1;
        start = cyc;
        serve("t6b", 20);
        if (ack_port_q.size() == 1) begin
            chk("t6b_lat", 32'(ack_cyc_q[0] - start), 32'd3);
            chk("t6b_rdata", ack_rdata_q[0], 32'h0BADF00D);
        end else chk("t6b_acks", 32'(ack_port_q.size()), 32'd1);

        // port-0 request dropped after grant, port 1 waiting
        clear_logs();
        p0_addr = 14'h0040; p0_req = 1'b1;
        start = cyc;
        step();
        p0_req = 1'b0; p0_addr = 14'h3FFC;
        p1_addr = 14'h0080; p1_we = 1'b0; p1_req = 1'b1;
        serve("t7", 40);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        check_order("t7");
        if (ack_cyc_q.size() == 2) begin
            chk("t7_lat0", 32'(ack_cyc_q[0] - start), 32'd3);
            chk("t7_lat1", 32'(ack_cyc_q[1] - start), 32'd7);
        end
        if (strobe_addr_q.size() == 2) chk("t7_latched_addr", 32'(strobe_addr_q[0]), 32'h0040);

        chk("no_consecutive_strobes", 32'(consec), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
